// File: rtl/joybus_rx.sv
// Joybus response receiver: synchronises the open-drain line,
// times each device bit from its falling edge and assembles bytes.
module joybus_rx #(
  parameter int SAMPLE_CYC  = 48,
  parameter int LOW_MAX_CYC = 96,
  parameter int TIMEOUT_CYC = 2400,
  parameter int MAX_BYTES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       JB_RX,
  input  logic       tx_done,
  input  logic [3:0] rsp_bytes,
  output logic [7:0] rx_data,
  output logic       rx_byte_vld,
  output logic       rx_done,
  output logic       rx_timeout,
  output logic       rx_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    SAMPLE,
    WAIT_RISE,
    STOP_FALL,
    STOP_RISE,
    DONE
  } state_t;

  localparam logic [11:0] SAMPLE_PT = 12'(SAMPLE_CYC);
  localparam logic [11:0] TO_LAST   = 12'(TIMEOUT_CYC - 1);
  localparam logic [6:0]  LOW_LAST  = 7'(LOW_MAX_CYC - 1);
  localparam logic [3:0]  MAXB      = 4'(MAX_BYTES);

  state_t      state;
  logic        s1;
  logic        rx_s;
  logic        rx_prev;
  logic        fall;
  logic        timeout;
  logic        stuck;
  logic [11:0] cyc_cnt;
  logic [6:0]  low_cnt;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [3:0]  exp_bytes;
  logic [7:0]  shreg;
  logic        to_flag;
  logic        err_flag;

  assign fall    = rx_prev & ~rx_s;
  assign timeout = (cyc_cnt == TO_LAST);
  assign stuck   = ~rx_s && (low_cnt >= LOW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      s1      <= JB_RX;
      rx_s    <= s1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      exp_bytes   <= '0;
      shreg       <= '0;
      to_flag     <= 1'b0;
      err_flag    <= 1'b0;
      rx_data     <= 8'h00;
      rx_byte_vld <= 1'b0;
      rx_done     <= 1'b0;
      rx_timeout  <= 1'b0;
      rx_err      <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rx_byte_vld <= 1'b0;
      rx_done     <= 1'b0;
      rx_timeout  <= 1'b0;
      rx_err      <= 1'b0;
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 12'd1;
      if (low_cnt != '1) low_cnt <= low_cnt + 7'd1;
      unique case (state)
        IDLE: begin
          if (tx_done) begin
            exp_bytes <= (rsp_bytes > MAXB) ? MAXB : rsp_bytes;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rx_busy   <= 1'b1;
            cyc_cnt   <= '0;
            state     <= (rsp_bytes == 4'd0) ? DONE : WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          // rx_s has already been low two cycles when the fall is taken
          if (fall) begin
            state   <= SAMPLE;
            cyc_cnt <= '0;
            low_cnt <= 7'd2;
          end else if (timeout) begin
            state   <= DONE;
            to_flag <= 1'b1;
            cyc_cnt <= '0;
          end
        end
        SAMPLE: begin
          if (cyc_cnt == SAMPLE_PT) begin
            shreg   <= {shreg[6:0], rx_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data     <= {shreg[6:0], rx_s};
              rx_byte_vld <= 1'b1;
              byte_cnt    <= byte_cnt + 4'd1;
            end
            state   <= WAIT_RISE;
            cyc_cnt <= '0;
          end
        end
        WAIT_RISE: begin
          if (rx_s) begin
            state   <= (byte_cnt == exp_bytes) ? STOP_FALL : WAIT_FALL;
            cyc_cnt <= '0;
          end else if (stuck) begin
            state    <= DONE;
            err_flag <= 1'b1;
            cyc_cnt  <= '0;
          end
        end
        STOP_FALL: begin
          if (fall) begin
            state   <= STOP_RISE;
            cyc_cnt <= '0;
            low_cnt <= 7'd2;
          end else if (timeout) begin
            state   <= DONE;
            to_flag <= 1'b1;
            cyc_cnt <= '0;
          end
        end
        STOP_RISE: begin
          if (rx_s) begin
            state   <= DONE;
            cyc_cnt <= '0;
          end else if (stuck) begin
            state    <= DONE;
            err_flag <= 1'b1;
            cyc_cnt  <= '0;
          end
        end
        DONE: begin
          rx_done    <= 1'b1;
          rx_timeout <= to_flag;
          rx_err     <= err_flag;
          rx_busy    <= 1'b0;
          to_flag    <= 1'b0;
          err_flag   <= 1'b0;
          cyc_cnt    <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_rx.sv
// Directed bench for joybus_rx: drives device replies on JB_RX and
// checks bytes, completion flags, timing and busy against a model.
module tb_joybus_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       JB_RX = 1'b1;
  logic       tx_done = 1'b0;
  logic [3:0] rsp_bytes = 4'd0;
  logic [7:0] rx_data;
  logic       rx_byte_vld;
  logic       rx_done;
  logic       rx_timeout;
  logic       rx_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  bit  busy_m = 0;
  bit  done_pend = 0;
  bit  exp_to = 0;
  bit  exp_err = 0;
  int  win_lo = 0;
  int  win_hi = 0;

  joybus_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .JB_RX      (JB_RX),
    .tx_done    (tx_done),
    .rsp_bytes  (rsp_bytes),
    .rx_data    (rx_data),
    .rx_byte_vld(rx_byte_vld),
    .rx_done    (rx_done),
    .rx_timeout (rx_timeout),
    .rx_err     (rx_err),
    .rx_busy    (rx_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (rx_byte_vld) begin
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("rx_data", rx_data, exp_q.pop_front());
      end
      if (rx_done) begin
        chk("done_expected", done_pend, 1);
        if (done_pend) begin
          chk("rx_timeout", rx_timeout, exp_to);
          chk("rx_err", rx_err, exp_err);
          checks++;
          if (cyc < win_lo || cyc > win_hi) begin
            failures++;
            $display("FAIL done_time: got cyc %0d expected %0d..%0d",
                     cyc, win_lo, win_hi);
          end
        end
        chk("busy_at_done", rx_busy, 0);
        busy_m = 0;
        done_pend = 0;
      end else begin
        chk("rx_busy", rx_busy, busy_m);
        chk("timeout_alone", rx_timeout, 0);
        chk("err_alone", rx_err, 0);
      end
    end
  end

  task automatic arm(input logic [3:0] n, output int t);
    @(negedge clk);
    tx_done = 1'b1;
    rsp_bytes = n;
    t = cyc;
    @(negedge clk);
    tx_done = 1'b0;
    busy_m = 1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    JB_RX = 1'b0;
    wait_cyc(b ? 24 : 72);
    JB_RX = 1'b1;
    wait_cyc(b ? 72 : 24);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    JB_RX = 1'b0;
    wait_cyc(48);
    JB_RX = 1'b1;
    exp_to = 0;
    exp_err = 0;
    win_lo = cyc + 3;
    win_hi = cyc + 4;
    done_pend = 1;
  endtask

  task automatic end_test(input string name, input int budget);
    int k = 0;
    while (done_pend && k < budget) begin
      @(negedge clk);
      k++;
    end
    wait_cyc(4);
    chk({name, "_done_seen"}, done_pend, 0);
    chk({name, "_bytes_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rx_data"}, rx_data, 8'h00);
    chk({name, "_vld"}, rx_byte_vld, 0);
    chk({name, "_done"}, rx_done, 0);
    chk({name, "_timeout"}, rx_timeout, 0);
    chk({name, "_err"}, rx_err, 0);
    chk({name, "_busy"}, rx_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int f;
    logic [7:0] dead;
    dead = 8'hAD;

    wait_cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(5);

    // single byte
    exp_q.push_back(8'hA5);
    arm(4'd1, t);
    wait_cyc(20);
    send_byte(8'hA5);
    send_stop();
    end_test("single", 50);
    chk("single_rx_data", rx_data, 8'hA5);

    // N64 status reply
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    arm(4'd3, t);
    wait_cyc(30);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h02);
    send_stop();
    end_test("n64", 50);
    chk("n64_rx_data", rx_data, 8'h02);

    // no reply at all
    arm(4'd4, t);
    exp_to = 1;
    exp_err = 0;
    win_lo = t + 2402;
    win_hi = t + 2402;
    done_pend = 1;
    end_test("timeout", 2600);

    // line stuck low mid-bit
    arm(4'd1, t);
    wait_cyc(20);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    JB_RX = 1'b0;
    f = cyc;
    exp_to = 0;
    exp_err = 1;
    win_lo = f + 96;
    win_hi = f + 99;
    done_pend = 1;
    wait_cyc(240);
    JB_RX = 1'b1;
    end_test("stuck", 20);
    chk("stuck_rx_data", rx_data, 8'h02);

    // zero length, tx_done held into the busy cycle
    @(negedge clk);
    tx_done = 1'b1;
    rsp_bytes = 4'd0;
    t = cyc;
    exp_to = 0;
    exp_err = 0;
    win_lo = t + 2;
    win_hi = t + 2;
    done_pend = 1;
    @(negedge clk);
    busy_m = 1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_cyc(30);
    end_test("zero", 10);

    // oversize request clamps to eight bytes
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h31 + i * 8'h11));
    arm(4'd9, t);
    wait_cyc(20);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i * 8'h11));
    send_stop();
    end_test("clamp", 50);
    chk("clamp_rx_data", rx_data, 8'hA8);

    // reset mid-frame
    exp_q.push_back(8'hDE);
    arm(4'd4, t);
    wait_cyc(20);
    send_byte(8'hDE);
    for (int i = 7; i >= 4; i--) send_bit(dead[i]);
    rst_n = 1'b0;
    busy_m = 0;
    done_pend = 0;
    exp_q.delete();
    wait_cyc(3);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    wait_cyc(10);
    chk("post_reset_rx_data", rx_data, 8'h00);
    exp_q.push_back(8'h12);
    arm(4'd1, t);
    wait_cyc(20);
    send_byte(8'h12);
    send_stop();
    end_test("after_reset", 50);
    chk("after_reset_rx_data", rx_data, 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
